// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide engine: 1-bit-per-cycle shift-add multiply and restoring divide.
// Feeds the HI/LO register data inputs; done doubles as their load enable.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_div, r_neg_q, r_neg_r, r_bzero;
    logic [N-1:0]    r_b, r_rem, r_quo;

    logic            w_accept, w_sa, w_sb;
    logic [N-1:0]    w_abs_a, w_abs_b;
    logic [N:0]      w_msum, w_shr;
    logic [N-1:0]    w_diff;
    logic            w_ge;
    logic [2*N-1:0]  w_prod, w_prod_s;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_sa     = op[0] & a[N-1];
    assign w_sb     = op[0] & b[N-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;

    // Multiply: r_rem is the upper accumulator, r_quo holds the multiplier shifting out.
    assign w_msum   = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : '0);

    // Divide: remainder < divisor, so the N-bit wrapped difference is exact whenever w_ge.
    assign w_shr    = {r_rem, r_quo[N-1]};
    assign w_ge     = w_shr[N] | (w_shr[N-1:0] >= r_b);
    assign w_diff   = w_shr[N-1:0] - r_b;

    assign w_prod   = {r_rem, r_quo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;

    assign busy = (r_state == S_CALC) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (r_cnt == CW'(N-1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
            r_b     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_div   <= op[1];
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_bzero <= op[1] && (b == '0);
            r_b     <= op[1] ? w_abs_b : w_abs_a;
            r_rem   <= '0;
            r_quo   <= op[1] ? w_abs_a : w_abs_b;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_div) begin
                {r_rem, r_quo} <= {w_msum, r_quo[N-1:1]};
            end else if (w_ge) begin
                r_rem <= w_diff;
                r_quo <= {r_quo[N-2:0], 1'b1};
            end else begin
                r_rem <= w_shr[N-1:0];
                r_quo <= {r_quo[N-2:0], 1'b0};
            end
        end else if (r_state == S_FIX) begin
            if (r_div) begin
                lo <= r_bzero ? '1 : (r_neg_q ? -r_quo : r_quo);
                hi <= r_neg_r ? -r_rem : r_rem;
            end else begin
                {hi, lo} <= w_prod_s;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, boundaries, back-to-back, abort.
module tb_muldiv_unit;
    logic        clk, rst, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    int n, bc, seen;

    muldiv_unit #(.N(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Start is presented for exactly one edge; inputs are scrambled afterwards.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 0; bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input bit chk_pulse);
        int c, bcl;
        issue(o, x, y);
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        wait_done(c, bcl);
        chk({tag, " latency"}, 32'(c), 32'd33);
        chk({tag, " busy_cycles"}, 32'(bcl), 32'd33);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        if (chk_pulse) begin
            @(posedge clk); #1;
            chk({tag, " done_single_pulse"}, 32'(done), 32'd0);
            chk({tag, " hi_hold"}, hi, eh);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        run("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
        run("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
        run("divu",      2'b10, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b1);
        run("div_nn",    2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        run("div_pn",    2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1);
        run("divu_zero", 2'b10, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        run("div_zero",  2'b11, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
        run("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);

        // start while busy must be ignored
        issue(2'b00, 32'd3, 32'd4);
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, bc);
        chk("ignore latency", 32'(n), 32'd27);
        chk("ignore hi", hi, 32'd0);
        chk("ignore lo", lo, 32'd12);

        // issued in the DONE cycle of the previous op
        run("b2b", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run("b2b2", 2'b00, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b1);

        // reset in the middle of CALC
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        rst = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort no_done", 32'(seen), 32'd0);

        run("recover", 2'b10, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
